seg_disp_arb: RTL and testbench
===============================

Name: seg_disp_arb

Overview:
- Arbiter and sequencer that shares the 4-digit 7-segment scanner between two requesters.
- Grants the display round-robin and latches the winner's 8-bit binary value.
- Converts the value to BCD serially (shift-add-3, one bit per cycle) and presents a blanked 4-nibble display word to the scanner.
- Holds the display for a minimum time before it can be handed to another requester.

Parameters:
- HOLD_CNT, 5_000_000, minimum display hold in clk cycles after each update; legal range ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  display request, one bit per requester; level-sensitive.
- val0  in  8  binary value from requester 0.
- val1  in  8  binary value from requester 1.
- gnt  out  2  one-hot grant; 2'b00 when idle.
- busy  out  1  high in CONV and HOLD.
- disp_word  out  16  four display nibbles {d3,d2,d1,d0}, d0 = ones; value 4'hB means blank digit.
- upd  out  1  one-cycle pulse when disp_word takes a new value.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port rst.
- Reset values: state = IDLE, gnt = 0, busy = 0, upd = 0, disp_word = 16'hBBBB, rr_ptr = 0. rr_ptr names the requester that wins a tie.
- Reset is sampled only on a clk edge. Asserting it mid-CONV or mid-HOLD aborts the operation: no upd pulse, and disp_word is blanked.
- States: IDLE, CONV, HOLD.
- IDLE, grant selection:
  - If req != 0 at edge T, select the winner: the single requester if only one is active; rr_ptr if both are active.
  - At T+1: gnt = onehot(winner), the winner's val is latched into an 8-bit shift register, the BCD accumulator (12 bit) is cleared, bit counter = 0, state = CONV.
  - After a grant, rr_ptr = the other requester.
- CONV, per cycle (8 cycles, counter 0..7):
  - Each BCD nibble ≥ 5 gets +3.
  - Then {bcd, sreg} is shifted left by 1.
  - After the 8th shift, the next edge (T+9) writes disp_word, pulses upd, loads the hold counter with HOLD_CNT-1, and moves to HOLD.
  - Latency: grant edge to disp_word valid is exactly 8 cycles; request sample to upd is 9 cycles.
- Blanking:
  - d3 = 4'hB.
  - d2 = 4'hB if hundreds = 0.
  - d1 = 4'hB if hundreds = 0 and tens = 0.
  - d0 is always shown.
- HOLD:
  - The counter decrements every cycle.
  - At counter = 0, gnt is deasserted and the next step depends on req:
    - Other requester's req high: it is granted next cycle (as in IDLE).
    - Only the current requester's req high: it is re-granted next cycle and val is re-sampled (refresh).
    - req = 0: go to IDLE.
- Latched value: val changes during CONV or HOLD are ignored until the next grant.
- req deasserted mid-HOLD: the hold still runs to completion, and gnt stays high until HOLD ends.
- disp_word retention: disp_word holds its last value through IDLE and HOLD. It changes only on a CONV completion or on reset.
- Width rules: input values 0..255 map to at most 3 BCD digits, so no overflow is possible.

Optional Feature:
- Macro: OWNER_TAG_EN.
- Defined: d3 = 4'h0 when requester 0 owns the displayed value and 4'h1 when requester 1 owns it. Written with disp_word at CONV completion; blank (4'hB) after reset.
- Undefined: d3 is always 4'hB, and no owner register is synthesised.

Test Plan (HOLD_CNT = 16 in bench):
1. Reset, then req = 01, val0 = 49 → gnt = 01 one cycle later; 8 cycles after the grant, disp_word = 16'hBB49 with a single-cycle upd; busy high from grant to end of HOLD.
2. From reset, req = 11, val0 = 7, val1 = 200 → requester 0 wins first, disp_word = 16'hBBB7; after 16 HOLD cycles, gnt = 10 and disp_word = 16'hB200.
3. req held at 11 for 4 grants → gnt alternates 01, 10, 01, 10; no grant without an intervening HOLD of 16 cycles.
4. Single requester with val0 = 0, then 100, then 255 (changed during HOLD) → 16'hBBB0, 16'hB100, 16'hB255. Each value appears only after the next refresh grant; a change during CONV has no effect on the current conversion.
5. rst pulsed on the 4th CONV cycle → next edge gnt = 0, busy = 0, disp_word = 16'hBBBB, no upd; a later req = 10 is granted (rr_ptr = 0, but only requester 1 is active).
6. req dropped 3 cycles into HOLD → HOLD completes all 16 cycles, then IDLE with gnt = 0, and disp_word keeps its last value. With OWNER_TAG_EN defined, scenario 2 yields 16'h0BB7 then 16'h1200.

Source files
------------

// File: rtl/seg_disp_arb.sv
// Round-robin arbiter sharing a 4-digit 7-segment scanner; serial binary-to-BCD.
// Optional OWNER_TAG_EN: d3 shows the owning requester instead of blank.
module seg_disp_arb #(
    parameter int unsigned HOLD_CNT = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [7:0]  val0,
    input  logic [7:0]  val1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [15:0] disp_word,
    output logic        upd
);

    localparam int unsigned HW = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CNT - 1);
    localparam logic [3:0] BLANK = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          rr_q, rr_d;
    logic [7:0]    sreg_q, sreg_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    bit_q, bit_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [11:0]   dlo_q, dlo_d;
    logic          upd_q, upd_d;
`ifdef OWNER_TAG_EN
    logic [3:0]    tag_q, tag_d;
`endif

    logic        win;
    logic [11:0] adj;
    logic [11:0] bcd_sh;
    logic [3:0]  hun, ten, one;
    logic [11:0] dlo_new;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Tie goes to rr_q; a lone requester always wins.
    assign win = req[1] & (~req[0] | rr_q);

    assign adj    = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    assign bcd_sh = {adj[10:0], sreg_q[7]};
    assign hun    = bcd_sh[11:8];
    assign ten    = bcd_sh[7:4];
    assign one    = bcd_sh[3:0];

    assign dlo_new = {
        (hun == 4'd0) ? BLANK : hun,
        ((hun == 4'd0) && (ten == 4'd0)) ? BLANK : ten,
        one
    };

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        sreg_d  = sreg_q;
        bcd_d   = bcd_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        dlo_d   = dlo_q;
        upd_d   = 1'b0;
`ifdef OWNER_TAG_EN
        tag_d   = tag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    sreg_d  = win ? val1 : val0;
                    bcd_d   = 12'd0;
                    bit_d   = 3'd0;
                    rr_d    = ~win;
                    state_d = CONV;
                end
            end
            CONV: begin
                sreg_d = {sreg_q[6:0], 1'b0};
                bcd_d  = bcd_sh;
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    dlo_d   = dlo_new;
                    upd_d   = 1'b1;
                    hold_d  = HOLD_LD;
                    state_d = HOLD;
`ifdef OWNER_TAG_EN
                    tag_d   = {3'b000, gnt_q[1]};
`endif
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            rr_q    <= 1'b0;
            sreg_q  <= 8'd0;
            bcd_q   <= 12'd0;
            bit_q   <= 3'd0;
            hold_q  <= '0;
            dlo_q   <= {BLANK, BLANK, BLANK};
            upd_q   <= 1'b0;
`ifdef OWNER_TAG_EN
            tag_q   <= BLANK;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            sreg_q  <= sreg_d;
            bcd_q   <= bcd_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            dlo_q   <= dlo_d;
            upd_q   <= upd_d;
`ifdef OWNER_TAG_EN
            tag_q   <= tag_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);
    assign upd  = upd_q;
`ifdef OWNER_TAG_EN
    assign disp_word = {tag_q, dlo_q};
`else
    assign disp_word = {BLANK, dlo_q};
`endif

endmodule

// File: tb/tb_seg_disp_arb.sv
// Scoreboard bench for seg_disp_arb with HOLD_CNT = 16.
module tb_seg_disp_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [7:0]  val0 = 8'd0;
    logic [7:0]  val1 = 8'd0;
    logic [1:0]  gnt;
    logic        busy;
    logic [15:0] disp_word;
    logic        upd;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] expq[$];
    logic prev_upd = 1'b0;

    seg_disp_arb #(.HOLD_CNT(16)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .val0(val0),
        .val1(val1),
        .gnt(gnt),
        .busy(busy),
        .disp_word(disp_word),
        .upd(upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ew(input logic [15:0] w, input bit own);
`ifdef OWNER_TAG_EN
        return {own ? 4'h1 : 4'h0, w[11:0]};
`else
        return w;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        tick(2);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_disp", 32'(disp_word), 32'hBBBB);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_grant(input logic [1:0] eg, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 2'b00 && n < 200);
        chk("grant", 32'(gnt), 32'(eg));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt != 2'b00 && n < 200);
        chk("idle", 32'(gnt), 32'h0);
    endtask

    // Monitor: every upd pulse consumes one expected display word.
    always @(negedge clk) begin
        if (upd) begin
            if (prev_upd) chk("upd_single", 32'(prev_upd), 32'h0);
            if (expq.size() == 0) begin
                chk("upd_unexpected", 32'(disp_word), 32'hFFFF_FFFF);
            end else begin
                chk("disp_word", 32'(disp_word), 32'(expq.pop_front()));
            end
        end
        prev_upd = upd;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int c;
        do_reset();

        // 1: single requester, 49
        val0 = 8'd49;
        req = 2'b01;
        expq.push_back(ew(16'hBB49, 0));
        tick(1);
        chk("s1_gnt", 32'(gnt), 32'h1);
        chk("s1_busy", 32'(busy), 32'h1);
        req = 2'b00;
        tick(7);
        chk("s1_upd_early", 32'(upd), 32'h0);
        chk("s1_disp_early", 32'(disp_word), 32'hBBBB);
        tick(1);
        chk("s1_upd", 32'(upd), 32'h1);
        tick(15);
        chk("s1_hold_gnt", 32'(gnt), 32'h1);
        chk("s1_hold_busy", 32'(busy), 32'h1);
        tick(1);
        chk("s1_end_gnt", 32'(gnt), 32'h0);
        chk("s1_end_busy", 32'(busy), 32'h0);
        chk("s1_keep", 32'(disp_word), 32'(ew(16'hBB49, 0)));

        // 2: both request from reset
        do_reset();
        val0 = 8'd7;
        val1 = 8'd200;
        req = 2'b11;
        expq.push_back(ew(16'hBBB7, 0));
        expq.push_back(ew(16'hB200, 1));
        wait_grant(2'b01, n);
        wait_idle();
        wait_grant(2'b10, n);
        chk("s2_gap", 32'(n), 32'd1);
        req = 2'b00;
        wait_idle();

        // 3: alternating grants, 24 granted cycles each
        val0 = 8'd1;
        val1 = 8'd2;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            expq.push_back(ew((i % 2) ? 16'hBBB2 : 16'hBBB1, (i % 2) == 1));
            wait_grant((i % 2) ? 2'b10 : 2'b01, n);
            chk("s3_wait", 32'(n), 32'd1);
            if (i == 3) req = 2'b00;
            c = 1;
            while (gnt != 2'b00 && c < 100) begin
                @(negedge clk);
                if (gnt != 2'b00) c++;
            end
            chk("s3_len", 32'(c), 32'd24);
        end

        // 4: refresh with changing value
        do_reset();
        val0 = 8'd0;
        req = 2'b01;
        expq.push_back(ew(16'hBBB0, 0));
        expq.push_back(ew(16'hB100, 0));
        expq.push_back(ew(16'hB255, 0));
        wait_grant(2'b01, n);
        tick(2);
        val0 = 8'd100;
        wait_idle();
        wait_grant(2'b01, n);
        tick(12);
        val0 = 8'd255;
        wait_idle();
        wait_grant(2'b01, n);
        req = 2'b00;
        wait_idle();

        // 5: reset mid-CONV
        val0 = 8'd77;
        req = 2'b01;
        wait_grant(2'b01, n);
        tick(3);
        rst = 1'b1;
        req = 2'b00;
        tick(1);
        chk("s5_gnt", 32'(gnt), 32'h0);
        chk("s5_busy", 32'(busy), 32'h0);
        chk("s5_upd", 32'(upd), 32'h0);
        chk("s5_disp", 32'(disp_word), 32'hBBBB);
        rst = 1'b0;
        tick(12);
        val1 = 8'd42;
        req = 2'b10;
        expq.push_back(ew(16'hBB42, 1));
        wait_grant(2'b10, n);
        req = 2'b00;
        wait_idle();

        // 6: req dropped during HOLD
        val0 = 8'd123;
        req = 2'b01;
        expq.push_back(ew(16'hB123, 0));
        wait_grant(2'b01, n);
        tick(11);
        req = 2'b00;
        tick(12);
        chk("s6_hold_gnt", 32'(gnt), 32'h1);
        chk("s6_hold_busy", 32'(busy), 32'h1);
        tick(1);
        chk("s6_end_gnt", 32'(gnt), 32'h0);
        chk("s6_end_busy", 32'(busy), 32'h0);
        tick(3);
        chk("s6_keep", 32'(disp_word), 32'(ew(16'hB123, 0)));
        chk("s6_idle", 32'(gnt), 32'h0);

        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
